// File: rtl/tiger_dmem_port.sv
// Posted-write data-memory port: a small write buffer feeding an Avalon-MM master.
// Store acceptance is a single cycle; a load result is valid one cycle after avm_readdatavalid.
// memCanWrite drops when the buffer is full; loads and flushes wait for an idle, empty buffer.

// Generic synchronous FIFO holding the posted-write entries.
// Zero-latency read of the head entry; a push is visible at the head the cycle after.
// Pushes into a full FIFO and pops from an empty one are ignored.
module tiger_dmem_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_dat,
  input  logic                       pop,
  output logic [WIDTH-1:0]           pop_dat,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign pop_dat = mem[rptr];

  // Storage array; contents are only meaningful between the pointers, so no reset.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wptr] <= push_dat;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push_ok) wptr <= wptr + AW'(1);
      if (pop_ok)  rptr <= rptr + AW'(1);
      count <= count + CW'(push_ok) - CW'(pop_ok);
    end
  end
endmodule

module tiger_dmem_port #(
  parameter int WBUF_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memread,
  input  logic        memwrite,
  input  logic        mem16,
  input  logic        mem8,
  input  logic [31:0] memaddress,
  input  logic [31:0] memwritedata,
  output logic        memCanRead,
  output logic        memCanWrite,
  input  logic        dCacheFlush,
  output logic        canDCacheFlush,
  output logic [31:0] memreaddata,
  output logic        memreaddataValid,
  output logic [31:0] avm_address,
  output logic        avm_read,
  output logic        avm_write,
  output logic [3:0]  avm_byteenable,
  output logic [31:0] avm_writedata,
  input  logic [31:0] avm_readdata,
  input  logic        avm_readdatavalid,
  input  logic        avm_waitrequest
);
  localparam int CW = $clog2(WBUF_DEPTH+1);

  typedef struct packed {
    logic [29:0] word;
    logic [3:0]  be;
    logic [31:0] data;
  } wbuf_t;

  typedef enum logic [1:0] {IDLE, WR, RD_REQ, RD_WAIT} state_t;

  state_t      state, state_n;
  wbuf_t       wb_in, wb_head;
  logic [CW-1:0] wb_count;
  logic        wb_full, wb_empty, wb_pop;
  logic        wr_accept, rd_accept;
  logic [3:0]  fmt_be;
  logic [31:0] fmt_data;
  logic [1:0]  fmt_lane;
  logic [29:0] rd_word;
  logic [3:0]  rd_be;
  logic [1:0]  rd_lane;
  logic        rd_b8, rd_h16;
  logic [31:0] rd_shift, rd_ext;
  logic        unused_flush;

  // The flush request needs no action here: acceptance alone stalls the requester.
  assign unused_flush = dCacheFlush;

  assign memCanWrite    = !wb_full;
  assign memCanRead     = (state == IDLE) && wb_empty && !memwrite;
  assign canDCacheFlush = (state == IDLE) && wb_empty;
  assign wr_accept      = memwrite && !wb_full;
  assign rd_accept      = memread && memCanRead;

  // Byte enables, lane-replicated store data and load lane for the incoming request.
  always_comb begin
    fmt_be   = 4'b1111;
    fmt_data = memwritedata;
    fmt_lane = 2'b00;
    if (mem8) begin
      fmt_be   = 4'b0001 << memaddress[1:0];
      fmt_data = {4{memwritedata[7:0]}};
      fmt_lane = memaddress[1:0];
    end else if (mem16) begin
      fmt_be   = memaddress[1] ? 4'b1100 : 4'b0011;
      fmt_data = {2{memwritedata[15:0]}};
      fmt_lane = {memaddress[1], 1'b0};
    end
  end

  assign wb_in = '{word: memaddress[31:2], be: fmt_be, data: fmt_data};

  tiger_dmem_fifo #(.WIDTH($bits(wbuf_t)), .DEPTH(WBUF_DEPTH)) u_wbuf (
    .clk      (clk),
    .reset    (reset),
    .push     (wr_accept),
    .push_dat (wb_in),
    .pop      (wb_pop),
    .pop_dat  (wb_head),
    .count    (wb_count),
    .full     (wb_full),
    .empty    (wb_empty)
  );

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  // Next state and Avalon outputs; outputs come from stable registers so they hold under waitrequest.
  always_comb begin
    state_n        = state;
    wb_pop         = 1'b0;
    avm_read       = 1'b0;
    avm_write      = 1'b0;
    avm_address    = '0;
    avm_byteenable = '0;
    avm_writedata  = '0;
    case (state)
      IDLE: begin
        if (!wb_empty)      state_n = WR;
        else if (rd_accept) state_n = RD_REQ;
      end
      WR: begin
        avm_write      = 1'b1;
        avm_address    = {wb_head.word, 2'b00};
        avm_byteenable = wb_head.be;
        avm_writedata  = wb_head.data;
        if (!avm_waitrequest) begin
          wb_pop  = 1'b1;
          state_n = (wb_count > CW'(1) || wr_accept) ? WR : IDLE;
        end
      end
      RD_REQ: begin
        avm_read       = 1'b1;
        avm_address    = {rd_word, 2'b00};
        avm_byteenable = rd_be;
        if (!avm_waitrequest) state_n = RD_WAIT;
      end
      RD_WAIT: begin
        if (avm_readdatavalid) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Capture the load address and size when a read is accepted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_word <= '0;
      rd_be   <= '0;
      rd_lane <= '0;
      rd_b8   <= 1'b0;
      rd_h16  <= 1'b0;
    end else if (rd_accept) begin
      rd_word <= memaddress[31:2];
      rd_be   <= fmt_be;
      rd_lane <= fmt_lane;
      rd_b8   <= mem8;
      rd_h16  <= mem16 && !mem8;
    end
  end

  // Right-justify and zero-extend the addressed lanes of the returned word.
  always_comb begin
    rd_shift = avm_readdata >> {rd_lane, 3'b000};
    rd_ext   = rd_shift;
    if (rd_b8)       rd_ext = {24'b0, rd_shift[7:0]};
    else if (rd_h16) rd_ext = {16'b0, rd_shift[15:0]};
  end

  // Register the load result; valid is a one-cycle pulse, data holds until the next load.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      memreaddata      <= '0;
      memreaddataValid <= 1'b0;
    end else begin
      memreaddataValid <= (state == RD_WAIT) && avm_readdatavalid;
      if ((state == RD_WAIT) && avm_readdatavalid) memreaddata <= rd_ext;
    end
  end
endmodule

// File: tb/tb_tiger_dmem_port.sv
// Scoreboard bench for tiger_dmem_port with an Avalon-MM slave model.
// Stimulus pushes expected write/read transactions and load results into queues.
// A negedge monitor pops and compares whenever the DUT presents a transaction or result.
module tb_tiger_dmem_port;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        memread = 0, memwrite = 0, mem16 = 0, mem8 = 0;
  logic [31:0] memaddress = 0, memwritedata = 0;
  logic        memCanRead, memCanWrite;
  logic        dCacheFlush = 0, canDCacheFlush;
  logic [31:0] memreaddata;
  logic        memreaddataValid;
  logic [31:0] avm_address;
  logic        avm_read, avm_write;
  logic [3:0]  avm_byteenable;
  logic [31:0] avm_writedata;
  logic [31:0] avm_readdata = 0;
  logic        avm_readdatavalid = 0;
  logic        avm_waitrequest = 0;

  tiger_dmem_port #(.WBUF_DEPTH(4)) dut (
    .clk(clk), .reset(reset), .memread(memread), .memwrite(memwrite),
    .mem16(mem16), .mem8(mem8), .memaddress(memaddress), .memwritedata(memwritedata),
    .memCanRead(memCanRead), .memCanWrite(memCanWrite),
    .dCacheFlush(dCacheFlush), .canDCacheFlush(canDCacheFlush),
    .memreaddata(memreaddata), .memreaddataValid(memreaddataValid),
    .avm_address(avm_address), .avm_read(avm_read), .avm_write(avm_write),
    .avm_byteenable(avm_byteenable), .avm_writedata(avm_writedata),
    .avm_readdata(avm_readdata), .avm_readdatavalid(avm_readdatavalid),
    .avm_waitrequest(avm_waitrequest)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] a; logic [3:0] be; logic [31:0] d; } wexp_t;
  typedef struct { logic [31:0] a; logic [3:0] be; int hold; } rexp_t;
  wexp_t       wr_q[$];
  rexp_t       rq_q[$];
  logic [31:0] rd_q[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: bound expired waiting for DUT", name);
  endtask

  // ---------------- Avalon slave model ----------------
  logic [31:0] smem [logic [31:0]];
  int  wait_cfg = 0, ws_left = 0, rd_lat = 1, rd_cnt = -1;
  bit  ws_force = 0, hs_wr = 0, hs_rd = 0;
  logic [31:0] hs_addr, hs_data, rd_word;
  logic [3:0]  hs_be;

  function automatic logic [31:0] smem_rd(input logic [31:0] a);
    return smem.exists(a) ? smem[a] : 32'h0;
  endfunction

  always begin
    logic [31:0] w;
    @(posedge clk);
    #2;
    avm_readdatavalid = 1'b0;
    if (hs_wr) begin
      w = smem_rd(hs_addr);
      for (int k = 0; k < 4; k++) if (hs_be[k]) w[8*k +: 8] = hs_data[8*k +: 8];
      smem[hs_addr] = w;
    end
    if (hs_rd) begin
      rd_cnt  = rd_lat;
      rd_word = smem_rd(hs_addr);
    end
    hs_wr = 0;
    hs_rd = 0;
    if (rd_cnt == 0) begin
      avm_readdatavalid = 1'b1;
      avm_readdata      = rd_word;
      rd_cnt            = -1;
    end else if (rd_cnt > 0) begin
      rd_cnt--;
    end
    if (ws_force) begin
      avm_waitrequest = 1'b1;
    end else if (avm_read || avm_write) begin
      if (ws_left > 0) begin
        avm_waitrequest = 1'b1;
        ws_left--;
      end else begin
        avm_waitrequest = 1'b0;
        ws_left = wait_cfg;
        hs_wr   = avm_write;
        hs_rd   = avm_read;
        hs_addr = avm_address;
        hs_be   = avm_byteenable;
        hs_data = avm_writedata;
      end
    end else begin
      avm_waitrequest = 1'b0;
    end
  end

  // ---------------- Monitor / scoreboard ----------------
  logic        p_req = 0, p_wr = 0, p_rdv = 0, p_vld = 0;
  logic [69:0] p_bus = '0;
  int hold = 0;

  always @(negedge clk) begin
    wexp_t we;
    rexp_t re;
    if (reset) begin
      p_req = 0; p_wr = 0; p_rdv = 0; p_vld = 0; hold = 0;
    end else begin
      if (avm_read || avm_write)
        chk("rw_exclusive", 96'(avm_read && avm_write), 96'(0));
      if (p_req && p_wr)
        chk("hold_stable", 96'({avm_read, avm_write, avm_byteenable, avm_address, avm_writedata}), 96'(p_bus));
      if (avm_read) hold++;
      if (avm_write && !avm_waitrequest) begin
        if (wr_q.size() == 0) timeout_fail("unexpected_write");
        else begin
          we = wr_q.pop_front();
          chk("write_xact", 96'({avm_address, avm_byteenable, avm_writedata}), 96'({we.a, we.be, we.d}));
        end
      end
      if (avm_read && !avm_waitrequest) begin
        chk("read_bypass", 96'(wr_q.size()), 96'(0));
        if (rq_q.size() == 0) timeout_fail("unexpected_read");
        else begin
          re = rq_q.pop_front();
          chk("read_xact", 96'({avm_address, avm_byteenable, 8'(hold)}), 96'({re.a, re.be, 8'(re.hold)}));
        end
        hold = 0;
      end
      if (memreaddataValid) begin
        chk("valid_timing", 96'(p_rdv), 96'(1));
        chk("valid_pulse", 96'(p_vld), 96'(0));
        if (rd_q.size() == 0) timeout_fail("unexpected_load");
        else chk("load_data", 96'(memreaddata), 96'(rd_q.pop_front()));
      end
      p_req = avm_read || avm_write;
      p_wr  = avm_waitrequest;
      p_bus = {avm_read, avm_write, avm_byteenable, avm_address, avm_writedata};
      p_rdv = avm_readdatavalid;
      p_vld = memreaddataValid;
    end
  end

  // ---------------- Stimulus ----------------
  // sz: 0 word, 1 half, 2 byte. Tasks start and end 1 time unit after a rising edge.
  task automatic store(input logic [31:0] a, input logic [31:0] d, input int sz,
                       input logic [31:0] ea, input logic [3:0] ebe, input logic [31:0] ed);
    bit ok = 0;
    memwrite = 1; memaddress = a; memwritedata = d; mem8 = (sz == 2); mem16 = (sz == 1);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (memCanWrite) begin ok = 1; break; end
    end
    if (!ok) timeout_fail("store_accept");
    else wr_q.push_back('{a: ea, be: ebe, d: ed});
    @(posedge clk); #1;
    memwrite = 0; mem8 = 0; mem16 = 0;
  endtask

  task automatic load(input logic [31:0] a, input int sz, input logic [31:0] ea,
                      input logic [3:0] ebe, input int ehold, input logic [31:0] edata);
    bit ok = 0;
    memread = 1; memaddress = a; mem8 = (sz == 2); mem16 = (sz == 1);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (memCanRead) begin ok = 1; break; end
    end
    if (!ok) timeout_fail("load_accept");
    else begin
      rq_q.push_back('{a: ea, be: ebe, hold: ehold});
      rd_q.push_back(edata);
    end
    @(posedge clk); #1;
    memread = 0; mem8 = 0; mem16 = 0;
  endtask

  task automatic drain();
    bit ok = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk); #1;
      if (canDCacheFlush && wr_q.size() == 0 && rq_q.size() == 0 && rd_q.size() == 0) begin
        ok = 1; break;
      end
    end
    if (!ok) timeout_fail("drain");
    @(posedge clk); #1;
  endtask

  task automatic set_wait(input int n);
    wait_cfg = n;
    ws_left  = n;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int late;
    smem[32'h2000] = 32'h12345678;

    // Reset state
    #1;
    chk("reset_avm", 96'({avm_read, avm_write, avm_byteenable, avm_address, avm_writedata}), 96'(0));
    chk("reset_rdata", 96'({memreaddata, memreaddataValid}), 96'(0));
    @(posedge clk); #1;
    reset = 0;
    @(negedge clk);
    chk("can_read_after_reset", 96'(memCanRead), 96'(1));
    chk("can_write_after_reset", 96'(memCanWrite), 96'(1));
    chk("can_flush_after_reset", 96'(canDCacheFlush), 96'(1));
    @(posedge clk); #1;

    // Store formatting: byte/half/word lanes, replication, ignored low address bits
    store(32'h1003, 32'h000000AB, 2, 32'h1000, 4'b1000, 32'hABABABAB);
    store(32'h1001, 32'hCCCC005A, 2, 32'h1000, 4'b0010, 32'h5A5A5A5A);
    store(32'h1006, 32'h0000BEEF, 1, 32'h1004, 4'b1100, 32'hBEEFBEEF);
    store(32'h1005, 32'h00001357, 1, 32'h1004, 4'b0011, 32'h13571357);
    store(32'h100E, 32'hDEADBEEF, 0, 32'h100C, 4'b1111, 32'hDEADBEEF);
    drain();

    // Halfword load with two waitrequest cycles
    set_wait(2);
    load(32'h2002, 1, 32'h2000, 4'b1100, 3, 32'h00001234);
    drain();
    set_wait(0);
    load(32'h2001, 2, 32'h2000, 4'b0010, 1, 32'h00000056);
    load(32'h2003, 2, 32'h2000, 4'b1000, 1, 32'h00000012);
    load(32'h2000, 0, 32'h2000, 4'b1111, 1, 32'h12345678);
    load(32'h1006, 1, 32'h1004, 4'b1100, 1, 32'h0000BEEF);
    load(32'h1003, 2, 32'h1000, 4'b1000, 1, 32'h000000AB);
    load(32'h100F, 0, 32'h100C, 4'b1111, 1, 32'hDEADBEEF);
    drain();

    // Fill the buffer while the slave stalls
    ws_force = 1;
    store(32'h3000, 32'h11111111, 0, 32'h3000, 4'b1111, 32'h11111111);
    store(32'h3004, 32'h22222222, 0, 32'h3004, 4'b1111, 32'h22222222);
    store(32'h3008, 32'h33333333, 0, 32'h3008, 4'b1111, 32'h33333333);
    store(32'h300C, 32'h44444444, 0, 32'h300C, 4'b1111, 32'h44444444);
    memwrite = 1; memaddress = 32'h3010; memwritedata = 32'h55555555;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("fill_full", 96'(memCanWrite), 96'(0));
    end
    @(posedge clk); #1;
    ws_force = 0;
    @(negedge clk);
    chk("full_on_dequeue", 96'(memCanWrite), 96'(0));
    @(posedge clk); #1;
    store(32'h3010, 32'h55555555, 0, 32'h3010, 4'b1111, 32'h55555555);
    drain();

    // Load after store to the same address must wait for the store
    set_wait(1);
    store(32'h0040, 32'hCAFEF00D, 0, 32'h0040, 4'b1111, 32'hCAFEF00D);
    memread = 1; memaddress = 32'h0040;
    @(negedge clk);
    chk("read_blocked_by_wbuf", 96'(memCanRead), 96'(0));
    @(posedge clk); #1;
    load(32'h0040, 0, 32'h0040, 4'b1111, 2, 32'hCAFEF00D);
    drain();

    // Simultaneous read and write: write wins, read is dropped
    set_wait(0);
    memread = 1; memwrite = 1; memaddress = 32'h0044; memwritedata = 32'h0BADF00D;
    @(negedge clk);
    chk("read_blocked_by_write", 96'(memCanRead), 96'(0));
    chk("write_taken_with_read", 96'(memCanWrite), 96'(1));
    wr_q.push_back('{a: 32'h0044, be: 4'b1111, d: 32'h0BADF00D});
    @(posedge clk); #1;
    memread = 0; memwrite = 0;
    drain();

    // Flush gating over three slow stores
    set_wait(2);
    store(32'h0050, 32'hA5A5A5A5, 0, 32'h0050, 4'b1111, 32'hA5A5A5A5);
    store(32'h0054, 32'h5A5A5A5A, 0, 32'h0054, 4'b1111, 32'h5A5A5A5A);
    store(32'h0058, 32'h0F0F0F0F, 0, 32'h0058, 4'b1111, 32'h0F0F0F0F);
    dCacheFlush = 1;
    begin
      bit ok = 0;
      for (int i = 0; i < 60; i++) begin
        @(posedge clk); #3;
        chk("flush_gate", 96'(canDCacheFlush), 96'(wr_q.size() == 0));
        if (canDCacheFlush) begin ok = 1; break; end
      end
      if (!ok) timeout_fail("flush_accept");
    end
    dCacheFlush = 0;
    @(posedge clk); #1;
    drain();

    // Reset while waiting for read data
    set_wait(0);
    rd_lat = 6;
    load(32'h2000, 0, 32'h2000, 4'b1111, 1, 32'h12345678);
    repeat (3) @(posedge clk);
    #1;
    reset = 1;
    #1;
    chk("reset_mid_avm", 96'({avm_read, avm_write, avm_byteenable, avm_address, avm_writedata}), 96'(0));
    chk("reset_mid_rdata", 96'({memreaddata, memreaddataValid}), 96'(0));
    rd_q.delete();
    repeat (2) @(posedge clk);
    #1;
    reset = 0;
    late = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (memreaddataValid) late++;
    end
    chk("late_valid_ignored", 96'(late), 96'(0));
    @(posedge clk); #1;
    rd_lat = 1;
    load(32'h2000, 2, 32'h2000, 4'b0001, 1, 32'h00000078);
    drain();

    chk("queues_empty", 96'(wr_q.size() + rq_q.size() + rd_q.size()), 96'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/tiger_dmem_port.md
TIGER_DMEM_PORT -- requirements
Module: tiger_dmem_port

Interface
REQ-001 SHALL have parameter WBUF_DEPTH, default 4: posted-write buffer entries, power of two, 2..16.
REQ-002 SHALL have port clk  in  1: sole clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  in  1: asynchronous, active-high.
REQ-004 SHALL have ports memread, memwrite, mem16, mem8  in  1 each: request type from the execute stage; mem16=mem8=0 means word.
REQ-005 SHALL have ports memaddress, memwritedata  in  32 each: byte address and store data, right-justified.
REQ-006 SHALL have ports memCanRead, memCanWrite  out  1 each: acceptance of read and write requests.
REQ-007 SHALL have ports dCacheFlush  in  1 and canDCacheFlush  out  1: drain request and its acceptance.
REQ-008 SHALL have ports memreaddata  out  32 and memreaddataValid  out  1: load result, right-justified and zero-extended.
REQ-009 SHALL have Avalon-MM master ports avm_address  out  32, avm_read  out  1, avm_write  out  1, avm_byteenable  out  4, avm_writedata  out  32.
REQ-010 SHALL have Avalon-MM inputs avm_readdata  in  32, avm_readdatavalid  in  1, avm_waitrequest  in  1.

Function
REQ-011 SHALL use a little-endian layout: byte lane k = addr[1:0] = k drives bits 8k+7:8k; a halfword uses lanes {2*addr[1]+1, 2*addr[1]}; addr[0] is ignored for halfwords and addr[1:0] for words.
REQ-012 SHALL drive avm_address = {memaddress[31:2], 2'b00} and byteenable 4'b0001<<a, 4'b0011<<(2*addr[1]), or 4'b1111 for byte, half, and word accesses respectively.
REQ-013 SHALL replicate store data across lanes: bytes x4, halfwords x2, words unchanged.
REQ-014 SHALL accept a write when memwrite && memCanWrite at a clock edge, enqueuing {address, byteenable, data} into the write buffer.
REQ-015 SHALL compute memCanWrite = !full, from the registered count only; a dequeue in the same cycle does not admit a write into a full buffer.
REQ-016 SHALL implement the FSM with states IDLE, WR, RD_REQ, RD_WAIT:
- IDLE->WR when the buffer is non-empty.
- WR holds avm_write with the head entry until avm_waitrequest=0, then dequeues; it stays in WR while entries remain, else returns to IDLE.
- IDLE->RD_REQ on an accepted read.
- RD_REQ holds avm_read until avm_waitrequest=0, then goes to RD_WAIT.
- RD_WAIT returns to IDLE on avm_readdatavalid.
REQ-017 SHALL assert memCanRead only in IDLE with an empty buffer and memwrite=0; reads therefore never bypass posted writes.
REQ-018 SHALL accept a read when memread && memCanRead; the address and size are latched, and avm_read is first asserted the following cycle.
REQ-019 SHALL register the extracted lanes on avm_readdatavalid and pulse memreaddataValid high for exactly one cycle on the next cycle; memreaddata holds its value until the next load.
REQ-020 SHALL give priority to the write when memread and memwrite are both high: the write is accepted and the read is not.
REQ-021 SHALL assert canDCacheFlush only in IDLE with an empty buffer; dCacheFlush while canDCacheFlush=0 has no effect beyond the requester stalling.
REQ-022 SHALL never assert avm_read and avm_write in the same cycle, and SHALL hold all avm_* outputs stable while avm_waitrequest=1.
REQ-023 SHALL wrap the buffer read and write pointers modulo WBUF_DEPTH, with count ranging 0..WBUF_DEPTH.
REQ-024 SHALL ignore avm_readdatavalid outside RD_WAIT.

Reset
REQ-025 SHALL, while reset=1, force state to IDLE, count and pointers to 0, avm_read=avm_write=0, avm_byteenable=0, avm_address=0, avm_writedata=0, memreaddata=0, and memreaddataValid=0.
REQ-026 SHALL abandon any outstanding transaction when reset asserts mid-operation; buffered writes are lost.
REQ-027 SHALL drive memCanRead=1, memCanWrite=1, and canDCacheFlush=1 after reset when memwrite=0.

Verification
REQ-028 Byte store: memwrite, mem8, addr 0x1003, data 0xAB -> avm_address 0x1000, byteenable 4'b1000, writedata 0xABABABAB, one write.
REQ-029 Halfword load: addr 0x2002 with avm_readdata 0x12345678 and 2 waitrequest cycles -> avm_read held 3 cycles; memreaddata 0x00001234 with one-cycle valid the cycle after readdatavalid.
REQ-030 Fill: 5 back-to-back word stores with waitrequest=1 -> first 4 accepted, memCanWrite=0 on the 5th; it is accepted after the first dequeue.
REQ-031 Ordering: a store to 0x40 followed by a load from 0x40 -> memCanRead=0 until the store completes; the load returns the stored value from the slave model.
REQ-032 Flush: 3 stores then dCacheFlush -> canDCacheFlush=0 until the 3rd avm_write completes, then 1.
REQ-033 Reset asserted in RD_WAIT -> all outputs take the REQ-025 values immediately; a late readdatavalid produces no memreaddataValid.
